if_fetch_unit: RTL

//  Instruction-fetch stage: owns the PC, issues word fetches to instruction memory over a req/ack handshake,

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_fifo.sv | 53 +++++
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: widths, FSM states,
// and the {pc+4, instr} bundle handed to the IF/ID register.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO of fetched {pc+4, instr} bundles.
// Flush empties it in one cycle; reset is synchronous, active-low.
module if_fetch_unit_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_0,
  input  logic          flush,
  input  logic          push,
  input  if_id_t        din,
  input  logic          pop,
  output if_id_t        dout,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  if_id_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_0 || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack FSM, fetch FIFO, redirect.
// Define IF_PERF_CNT_EN to add fetch/stall performance counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset_0,
  input  logic            enable,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_if,
  output logic [XLEN-1:0] pc4_if,
  output logic [XLEN-1:0] instr_if
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  if_state_e       state;
  if_state_e       state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nx;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_addr_nx;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic [CW-1:0]   avail;
  logic            empty;
  logic            push;
  logic            pop;
  logic            space_now;
  logic            space_post;
  if_id_t          head;
  if_id_t          wdata;

  assign target = redirect_pc & ~32'd3;
  assign empty  = (count == '0);
  assign pop    = enable && !empty;

  // Occupancy once this cycle's pop retires; an outstanding request
  // always owns one slot, so it can never overflow the FIFO.
  assign avail      = count - CW'(pop);
  assign space_now  = avail < CW'(BUF_DEPTH);
  assign space_post = (avail + CW'(1)) < CW'(BUF_DEPTH);

  assign wdata.pc4   = fetch_pc + PC_STEP;
  assign wdata.instr = imem_rdata;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    push        = 1'b0;
    unique case (state)
      IF_IDLE: begin
        if (redirect) begin
          fetch_pc_nx = target;
        end else if (space_now) begin
          state_nx    = IF_WAIT;
          req_addr_nx = fetch_pc;
        end
      end
      IF_WAIT: begin
        if (redirect) begin
          fetch_pc_nx = target;
          state_nx    = imem_ack ? IF_IDLE : IF_DROP;
        end else if (imem_ack) begin
          push        = 1'b1;
          fetch_pc_nx = fetch_pc + PC_STEP;
          if (space_post) begin
            req_addr_nx = fetch_pc + PC_STEP;
          end else begin
            state_nx = IF_IDLE;
          end
        end
      end
      IF_DROP: begin
        if (redirect) begin
          fetch_pc_nx = target;
        end
        if (imem_ack) begin
          state_nx = IF_IDLE;
        end
      end
      default: state_nx = IF_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_0) begin
      state    <= IF_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
    end
  end

  if_fetch_unit_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_0 (reset_0),
    .flush   (redirect),
    .push    (push),
    .din     (wdata),
    .pop     (pop),
    .dout    (head),
    .count   (count)
  );

  assign imem_req  = (state != IF_IDLE);
  assign imem_addr = req_addr;
  assign valid_if  = !empty;
  assign pc4_if    = valid_if ? head.pc4 : '0;
  assign instr_if  = valid_if ? head.instr : NOP_INSTR;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset_0) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (enable && empty) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
